// File: rtl/pll_ctrl_pkg.sv
// Shared types and verdict codes for the PLL lock controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_ctrl_pkg;

    // Loop sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMP_RST = 3'd1,
        ACQUIRE = 3'd2,
        TRACK   = 3'd3,
        LOCKED  = 3'd4
    } state_t;

    // Comparator verdict encodings
    localparam logic [1:0] ADJ_UP   = 2'b11;
    localparam logic [1:0] ADJ_DOWN = 2'b00;
    localparam logic [1:0] ADJ_HOLD = 2'b01;
    localparam logic [1:0] ADJ_BAD  = 2'b10;

    // Direction of the most recent coarse step
    typedef enum logic [1:0] {
        NONE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } dir_t;

endpackage

// File: rtl/pll_lock_controller_sat_step.sv
// Saturating add/subtract of a step to an unsigned frequency word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   Word   in  WORD_W  current word
//   Step   in  WORD_W  step magnitude
//   Down   in  1       1 = subtract, 0 = add
//   Result out WORD_W  word clamped to [0, 2^WORD_W-1]
module sat_step #(
    parameter int WORD_W = 8
) (
    input  logic [WORD_W-1:0] Word,
    input  logic [WORD_W-1:0] Step,
    input  logic              Down,
    output logic [WORD_W-1:0] Result
);

    logic [WORD_W:0] sum;

    always_comb begin
        sum    = {1'b0, Word} + {1'b0, Step};
        Result = Word;
        if (Down) begin
            Result = (Word < Step) ? '0 : (Word - Step);
        end else begin
            // Carry out of the top bit means the add overflowed
            Result = sum[WORD_W] ? '1 : sum[WORD_W-1:0];
        end
    end

endmodule

// File: rtl/pll_lock_controller.sv
// Steers the DCO word from comparator verdicts: coarse acquire, fine track, lock.
// Latency: a verdict strobed at cycle N updates FreqWord/Locked/LockLost at N+1.
// Backpressure: none; every AdjValid strobe is consumed, except in IDLE/CMP_RST or with Enable low.
//   Clk, Reset (sync, active-high), Enable, AdjustFreq[1:0], AdjValid in;
//   FreqWord[WORD_W-1:0], CmpReset, Locked, LockLost, CodeErr out (all registered).
module pll_lock_controller
    import pll_ctrl_pkg::*;
#(
    parameter int WORD_W         = 8,
    parameter int INIT_WORD      = 128,
    parameter int COARSE_STEP    = 8,
    parameter int LOCK_COUNT     = 4,
    parameter int UNLOCK_COUNT   = 2,
    parameter int CMP_RST_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [1:0]        AdjustFreq,
    input  logic              AdjValid,
    output logic [WORD_W-1:0] FreqWord,
    output logic              CmpReset,
    output logic              Locked,
    output logic              LockLost,
    output logic              CodeErr
);

    localparam logic [WORD_W-1:0] INIT_W   = WORD_W'(INIT_WORD);
    localparam logic [WORD_W-1:0] COARSE_W = WORD_W'(COARSE_STEP);
    localparam logic [WORD_W-1:0] FINE_W   = WORD_W'(1);
    localparam logic [3:0]        LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0]        UNLOCK_N = 4'(UNLOCK_COUNT);
    localparam logic [2:0]        RST_N    = 3'(CMP_RST_CYCLES);

    state_t      state;
    dir_t        lastDir;
    logic [3:0]  holdCnt;
    logic [3:0]  missCnt;
    logic [2:0]  rstCnt;

    logic              isUp;
    logic              isDown;
    logic              isHold;
    logic              isBad;
    logic              reversal;
    logic [WORD_W-1:0] stepSize;
    logic [WORD_W-1:0] steppedWord;

    assign isUp     = (AdjustFreq == ADJ_UP);
    assign isDown   = (AdjustFreq == ADJ_DOWN);
    assign isHold   = (AdjustFreq == ADJ_HOLD);
    assign isBad    = (AdjustFreq == ADJ_BAD);
    // A coarse step against the previous one means we bracketed the target
    assign reversal = (isUp && lastDir == DOWN) || (isDown && lastDir == UP);
    assign stepSize = (state == ACQUIRE) ? COARSE_W : FINE_W;

    sat_step #(
        .WORD_W (WORD_W)
    ) u_sat_step (
        .Word   (FreqWord),
        .Step   (stepSize),
        .Down   (isDown),
        .Result (steppedWord)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            lastDir  <= NONE;
            holdCnt  <= '0;
            missCnt  <= '0;
            rstCnt   <= '0;
            FreqWord <= INIT_W;
            CmpReset <= 1'b0;
            Locked   <= 1'b0;
            LockLost <= 1'b0;
            CodeErr  <= 1'b0;
        end else begin
            LockLost <= 1'b0;
            if (!Enable) begin
                // Word is held so the DCO stays put while the loop is open
                state    <= IDLE;
                lastDir  <= NONE;
                holdCnt  <= '0;
                missCnt  <= '0;
                rstCnt   <= '0;
                CmpReset <= 1'b0;
                Locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= CMP_RST;
                        FreqWord <= INIT_W;
                        CmpReset <= 1'b1;
                        rstCnt   <= 3'd1;
                    end
                    CMP_RST: begin
                        // rstCnt counts cycles CmpReset has already been high
                        if (rstCnt == RST_N) begin
                            state    <= ACQUIRE;
                            CmpReset <= 1'b0;
                            rstCnt   <= '0;
                            lastDir  <= NONE;
                        end else begin
                            rstCnt <= rstCnt + 3'd1;
                        end
                    end
                    ACQUIRE: begin
                        if (AdjValid) begin
                            if (isBad) begin
                                CodeErr <= 1'b1;
                            end else if (isHold) begin
                                state   <= TRACK;
                                holdCnt <= '0;
                            end else begin
                                FreqWord <= steppedWord;
                                lastDir  <= isUp ? UP : DOWN;
                                if (reversal) begin
                                    state   <= TRACK;
                                    holdCnt <= '0;
                                end
                            end
                        end
                    end
                    TRACK: begin
                        if (AdjValid) begin
                            if (isBad) begin
                                CodeErr <= 1'b1;
                            end else if (isHold) begin
                                if (holdCnt + 4'd1 == LOCK_N) begin
                                    state   <= LOCKED;
                                    Locked  <= 1'b1;
                                    holdCnt <= '0;
                                    missCnt <= '0;
                                end else begin
                                    holdCnt <= holdCnt + 4'd1;
                                end
                            end else begin
                                FreqWord <= steppedWord;
                                holdCnt  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (AdjValid) begin
                            if (isBad) begin
                                CodeErr <= 1'b1;
                            end else if (isHold) begin
                                missCnt <= '0;
                            end else begin
                                FreqWord <= steppedWord;
                                if (missCnt + 4'd1 == UNLOCK_N) begin
                                    state    <= TRACK;
                                    Locked   <= 1'b0;
                                    LockLost <= 1'b1;
                                    holdCnt  <= '0;
                                    missCnt  <= '0;
                                end else begin
                                    missCnt <= missCnt + 4'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_controller.sv
// Directed bench for pll_lock_controller: acquisition, lock, unlock, saturation, errors, reset.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pll_lock_controller;
    import pll_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic [1:0] AdjustFreq = ADJ_HOLD;
    logic       AdjValid = 1'b0;

    logic [7:0] FreqWord, FreqWordB, FreqWordC;
    logic       CmpReset, CmpResetB, CmpResetC;
    logic       Locked, LockedB, LockedC;
    logic       LockLost, LockLostB, LockLostC;
    logic       CodeErr, CodeErrB, CodeErrC;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pll_lock_controller dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .AdjustFreq(AdjustFreq), .AdjValid(AdjValid),
        .FreqWord(FreqWord), .CmpReset(CmpReset), .Locked(Locked), .LockLost(LockLost), .CodeErr(CodeErr)
    );

    // Near-top start word for upper saturation
    pll_lock_controller #(.INIT_WORD(250)) dutB (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .AdjustFreq(AdjustFreq), .AdjValid(AdjValid),
        .FreqWord(FreqWordB), .CmpReset(CmpResetB), .Locked(LockedB), .LockLost(LockLostB), .CodeErr(CodeErrB)
    );

    // Near-zero start word for lower saturation
    pll_lock_controller #(.INIT_WORD(3)) dutC (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .AdjustFreq(AdjustFreq), .AdjValid(AdjValid),
        .FreqWord(FreqWordC), .CmpReset(CmpResetC), .Locked(LockedC), .LockLost(LockLostC), .CodeErr(CodeErrC)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] code);
        AdjustFreq = code;
        AdjValid   = 1'b1;
        tick();
        AdjValid   = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1; Enable = 1'b0; AdjValid = 1'b0;
        tick(); tick();
        Reset = 1'b0;
    endtask

    // Enable, then wait out the comparator reset pulse into ACQUIRE
    task automatic start_loop();
        Enable = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (FreqWord !== 8'd128) begin errors++; $display("FAIL reset_word: got %0d expected 128", FreqWord); end
        checks++; if ({CmpReset, Locked, LockLost, CodeErr} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {CmpReset, Locked, LockLost, CodeErr}); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_acquire();
        Enable = 1'b1;
        tick();
        checks++; if (CmpReset !== 1'b1) begin errors++; $display("FAIL cmprst_c1: got %b expected 1", CmpReset); end
        // Verdict during comparator reset is dropped
        apply(ADJ_UP);
        checks++; if ({CmpReset, FreqWord} !== {1'b1, 8'd128}) begin errors++; $display("FAIL cmprst_c2: got %b/%0d expected 1/128", CmpReset, FreqWord); end
        tick();
        checks++; if (CmpReset !== 1'b0 || dut.state !== ACQUIRE) begin errors++; $display("FAIL cmprst_end: got %b/%0d expected 0/%0d", CmpReset, dut.state, ACQUIRE); end
        apply(ADJ_UP);
        checks++; if (FreqWord !== 8'd136) begin errors++; $display("FAIL acq_up1: got %0d expected 136", FreqWord); end
        apply(ADJ_UP);
        checks++; if (FreqWord !== 8'd144 || dut.state !== ACQUIRE) begin errors++; $display("FAIL acq_up2: got %0d/%0d expected 144/%0d", FreqWord, dut.state, ACQUIRE); end
        apply(ADJ_DOWN);
        checks++; if (FreqWord !== 8'd136 || dut.state !== TRACK) begin errors++; $display("FAIL acq_rev: got %0d/%0d expected 136/%0d", FreqWord, dut.state, TRACK); end
    endtask

    task automatic test_lock();
        apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD);
        apply(ADJ_UP);
        checks++; if (FreqWord !== 8'd137 || dut.holdCnt !== 4'd0) begin errors++; $display("FAIL track_up: got %0d/%0d expected 137/0", FreqWord, dut.holdCnt); end
        checks++; if (Locked !== 1'b0 || dut.state !== TRACK) begin errors++; $display("FAIL track_nolock: got %b/%0d expected 0/%0d", Locked, dut.state, TRACK); end
        apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD);
        checks++; if (Locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b expected 0", Locked); end
        apply(ADJ_HOLD);
        checks++; if (Locked !== 1'b1 || dut.state !== LOCKED) begin errors++; $display("FAIL lock: got %b/%0d expected 1/%0d", Locked, dut.state, LOCKED); end
    endtask

    task automatic test_unlock();
        apply(ADJ_DOWN);
        checks++; if ({Locked, LockLost, FreqWord} !== {1'b1, 1'b0, 8'd136}) begin errors++; $display("FAIL miss1: got %b/%b/%0d expected 1/0/136", Locked, LockLost, FreqWord); end
        apply(ADJ_DOWN);
        checks++; if ({Locked, LockLost, FreqWord} !== {1'b0, 1'b1, 8'd135}) begin errors++; $display("FAIL unlock: got %b/%b/%0d expected 0/1/135", Locked, LockLost, FreqWord); end
        tick();
        checks++; if (LockLost !== 1'b0 || dut.state !== TRACK) begin errors++; $display("FAIL lostpulse: got %b/%0d expected 0/%0d", LockLost, dut.state, TRACK); end
        apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD);
        apply(ADJ_DOWN); apply(ADJ_HOLD); apply(ADJ_DOWN);
        checks++; if ({Locked, LockLost, FreqWord} !== {1'b1, 1'b0, 8'd133}) begin errors++; $display("FAIL misshold: got %b/%b/%0d expected 1/0/133", Locked, LockLost, FreqWord); end
    endtask

    task automatic test_code_err();
        apply(ADJ_DOWN);
        checks++; if (LockLost !== 1'b1 || FreqWord !== 8'd132) begin errors++; $display("FAIL unlock2: got %b/%0d expected 1/132", LockLost, FreqWord); end
        apply(ADJ_HOLD);
        apply(ADJ_BAD);
        checks++; if ({CodeErr, FreqWord, dut.holdCnt} !== {1'b1, 8'd132, 4'd1}) begin errors++; $display("FAIL bad: got %b/%0d/%0d expected 1/132/1", CodeErr, FreqWord, dut.holdCnt); end
        apply(ADJ_HOLD);
        checks++; if (CodeErr !== 1'b1 || dut.holdCnt !== 4'd2) begin errors++; $display("FAIL bad_sticky: got %b/%0d expected 1/2", CodeErr, dut.holdCnt); end
        Enable = 1'b0;
        apply(ADJ_UP);
        checks++; if (dut.state !== IDLE || FreqWord !== 8'd132 || Locked !== 1'b0) begin errors++; $display("FAIL disable: got %0d/%0d/%b expected %0d/132/0", dut.state, FreqWord, Locked, IDLE); end
        checks++; if (CodeErr !== 1'b1) begin errors++; $display("FAIL disable_err: got %b expected 1", CodeErr); end
    endtask

    task automatic test_reset_mid();
        start_loop();
        apply(ADJ_HOLD);
        apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD); apply(ADJ_HOLD);
        checks++; if (Locked !== 1'b1 || FreqWord !== 8'd128) begin errors++; $display("FAIL relock: got %b/%0d expected 1/128", Locked, FreqWord); end
        apply(ADJ_UP);
        // This verdict would drop lock; reset must win
        Reset = 1'b1;
        apply(ADJ_UP);
        checks++; if ({FreqWord, Locked, LockLost, CodeErr} !== {8'd128, 3'b000}) begin errors++; $display("FAIL reset_mid: got %0d/%b/%b/%b expected 128/0/0/0", FreqWord, Locked, LockLost, CodeErr); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_mid_state: got %0d expected %0d", dut.state, IDLE); end
        Reset = 1'b0; Enable = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        start_loop();
        apply(ADJ_UP);
        checks++; if (FreqWordB !== 8'd255) begin errors++; $display("FAIL sat_hi1: got %0d expected 255", FreqWordB); end
        apply(ADJ_UP);
        checks++; if (FreqWordB !== 8'd255 || dutB.state !== ACQUIRE) begin errors++; $display("FAIL sat_hi2: got %0d/%0d expected 255/%0d", FreqWordB, dutB.state, ACQUIRE); end
        apply(ADJ_DOWN);
        checks++; if (FreqWordB !== 8'd247 || dutB.state !== TRACK) begin errors++; $display("FAIL sat_hi_rev: got %0d/%0d expected 247/%0d", FreqWordB, dutB.state, TRACK); end
        do_reset();
        start_loop();
        apply(ADJ_DOWN);
        checks++; if (FreqWordC !== 8'd0) begin errors++; $display("FAIL sat_lo1: got %0d expected 0", FreqWordC); end
        apply(ADJ_DOWN);
        checks++; if (FreqWordC !== 8'd0 || dutC.state !== ACQUIRE) begin errors++; $display("FAIL sat_lo2: got %0d/%0d expected 0/%0d", FreqWordC, dutC.state, ACQUIRE); end
        apply(ADJ_UP);
        checks++; if (FreqWordC !== 8'd8 || dutC.state !== TRACK) begin errors++; $display("FAIL sat_lo_rev: got %0d/%0d expected 8/%0d", FreqWordC, dutC.state, TRACK); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_lock();
        test_unlock();
        test_code_err();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_controller.md
# pll_lock_controller

Sequencer that closes the digital PLL loop around the jerky frequency comparator. Each comparator verdict (up / down / hold) steers a DCO frequency word through coarse acquisition, then fine tracking, to a declared lock. The block also resets the comparator at start of acquisition and reports loss of lock. It sits between the comparator's AdjustFreq output and the DCO control input, clocked by the system clock.

## Interface
- WORD_W, 8: DCO frequency word width.
- INIT_WORD, 128: word loaded at reset and at each acquisition start.
- COARSE_STEP, 8: step size in ACQUIRE.
- LOCK_COUNT, 4: consecutive hold verdicts needed in TRACK to declare lock (1..15).
- UNLOCK_COUNT, 2: consecutive non-hold verdicts in LOCKED that drop lock (1..15).
- CMP_RST_CYCLES, 2: comparator reset pulse length (1..7).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  reset Reset, synchronous, active-high.
- Enable  in  1  loop enable; low forces IDLE.
- AdjustFreq  in  2  comparator verdict: 2'b11 up, 2'b00 down, 2'b01 hold, 2'b10 illegal.
- AdjValid  in  1  one-cycle strobe; AdjustFreq is valid this cycle.
- FreqWord  out  WORD_W  DCO control word, registered.
- CmpReset  out  1  comparator reset, registered.
- Locked  out  1  lock indication, registered.
- LockLost  out  1  one-cycle pulse on LOCKED→TRACK.
- CodeErr  out  1  sticky: illegal code seen; cleared only by Reset.

## Operation
- Reset values: FreqWord=INIT_WORD, CmpReset=0, Locked=0, LockLost=0, CodeErr=0, state IDLE, all counters 0.
- States:
  - IDLE: word held. Enable=1 → CMP_RST, load INIT_WORD.
  - CMP_RST: CmpReset=1 for exactly CMP_RST_CYCLES cycles; verdicts ignored. Then → ACQUIRE, last-direction cleared.
  - ACQUIRE: up → +COARSE_STEP; down → −COARSE_STEP. If the direction is opposite to the previous step, apply the step and → TRACK. Hold → TRACK with no change.
  - TRACK: up → +1, down → −1, each clearing hold_cnt. Hold → hold_cnt+1. When hold_cnt reaches LOCK_COUNT → LOCKED, Locked=1.
  - LOCKED: up/down still apply ±1 and increment miss_cnt; hold clears miss_cnt. When miss_cnt reaches UNLOCK_COUNT → TRACK, Locked=0, LockLost=1 for one cycle, hold_cnt=0.
- Illegal code 2'b10: sets CodeErr. No word change, no state change, no counter change (not counted as hold or miss).
- Arithmetic: unsigned, saturating at 0 and 2^WORD_W−1. A saturated step still counts as a step for direction and counter rules.
- Enable=0 in any state → IDLE next cycle. FreqWord is held; Locked, CmpReset and counters are cleared.

## Timing
- Verdict with AdjValid at cycle N → FreqWord, state, Locked and LockLost updated at N+1.
- One verdict per AdjValid pulse. Back-to-back strobes on consecutive cycles are each processed.
- CmpReset rises the cycle after Enable is seen high in IDLE and lasts CMP_RST_CYCLES cycles.
- Simultaneous events:
  - Reset wins over everything.
  - Enable=0 wins over AdjValid; the verdict is dropped.
  - AdjValid during CMP_RST is dropped.
- Reset mid-operation: all outputs return to reset values at the next edge, including a LockLost in flight.

## Structure
- Package pll_ctrl_pkg holds:
  - the state enum (IDLE, CMP_RST, ACQUIRE, TRACK, LOCKED);
  - verdict constants ADJ_UP=2'b11, ADJ_DOWN=2'b00, ADJ_HOLD=2'b01, ADJ_BAD=2'b10;
  - the direction type (NONE, UP, DOWN).
- One sub-module: sat_step, combinational saturating add/sub of a step to a WORD_W word. The FSM, counters and output registers live in pll_lock_controller.

## Test plan
- Reset, then Enable=1 → CmpReset high for 2 cycles, FreqWord=128; then up,up,down → FreqWord 136,144,136 and state TRACK.
- In TRACK, four holds → Locked=1 the cycle after the 4th; three holds then an up → hold_cnt cleared, FreqWord+1, no lock.
- In LOCKED, down then down → FreqWord −1 twice, LockLost pulses once, Locked=0; down, hold, down → stays LOCKED.
- FreqWord=250 in ACQUIRE, up → 255 (saturated); up again → 255. Symmetric case at 3 with down → 0.
- Code 2'b10 in TRACK → CodeErr=1 sticky, FreqWord and hold_cnt unchanged; Enable=0 together with AdjValid → IDLE, verdict dropped.
- Reset asserted while LOCKED with a pending verdict → next cycle FreqWord=128, Locked=0, CodeErr=0, IDLE.
